// File: rtl/jt1943_dl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jt1943_dl_pkg
//  Purpose  : Shared types for the 1943 ROM download mapper: the buffered
//             SDRAM write entry, the download FSM states and the ROM region
//             selector produced by the address decoder.
//  Revision : 1.0  initial release
// ============================================================================
package jt1943_dl_pkg;

   // One pending SDRAM byte write: word address, byte value, active-low lane mask
   typedef struct packed {
      logic [21:0] addr;
      logic [7:0]  data;
      logic [1:0]  mask;
   } dl_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } dl_state_e;

   // Where a downloaded byte lands
   typedef enum logic [2:0] {
      RG_MAIN = 3'd0,
      RG_SND  = 3'd1,
      RG_CHAR = 3'd2,
      RG_GFX  = 3'd3,
      RG_PROM = 3'd4,
      RG_NONE = 3'd5
   } dl_region_e;

   localparam int c_FIFO_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/jt1943_dl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : jt1943_dl_fifo
//  Purpose  : Two-entry single-clock FIFO of SDRAM write entries. The head
//             entry is always visible on o_head. A push on a full FIFO is
//             accepted only when a pop happens in the same cycle.
//  Ports    : clk, rst      clock, synchronous active-high reset
//             i_push/i_pop  push request / pop request (ignored when empty)
//             i_entry       entry to push
//             o_head        oldest entry
//             o_full/o_empty occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module jt1943_dl_fifo
   import jt1943_dl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_push,
   input  logic      i_pop,
   input  dl_entry_t i_entry,
   output dl_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   dl_entry_t  r_mem [c_FIFO_DEPTH];
   logic       r_wp;
   logic       r_rp;
   logic [1:0] r_cnt;

   logic w_pop;
   logic w_push;

   assign w_pop  = i_pop  && (r_cnt != 2'd0);
   // When full, a simultaneous pop frees the slot being written
   assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= i_entry;
            r_wp        <= ~r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head  = r_mem[r_rp];
   assign o_full  = (r_cnt == 2'd2);
   assign o_empty = (r_cnt == 2'd0);

endmodule
`default_nettype wire

// File: rtl/jt1943_dl_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : jt1943_dl_mapper
//  Purpose  : Maps the hps_io byte download stream onto SDRAM word writes
//             (with lane masks) and on-chip PROM write strobes. SDRAM writes
//             are buffered two deep against prog_ack back-pressure.
//  Ports    : clk, rst                  clock, synchronous active-high reset
//             i_downloading             download in progress
//             i_ioctl_wr/addr/data      byte write strobe, byte address, byte
//             o_prog_addr/data/mask/we  SDRAM write request (held until ack)
//             i_prog_ack                SDRAM accepted the current request
//             o_prom_we/addr/data       one-hot PROM write pulse, address, nibble
//             o_dl_done                 one-cycle pulse when download is flushed
//             o_dl_ovf                  sticky: a byte was dropped (buffer full)
//  Revision : 1.0  initial release
// ============================================================================
module jt1943_dl_mapper
   import jt1943_dl_pkg::*;
#(
   parameter logic [24:0] SND_START  = 25'h0C000,
   parameter logic [24:0] CHAR_START = 25'h14000,
   parameter logic [24:0] GFX_START  = 25'h1C000,
   parameter logic [24:0] PROM_START = 25'h9C000,
   parameter logic [21:0] SND_BASE   = 22'h08000,
   parameter logic [21:0] CHAR_BASE  = 22'h0C000,
   parameter logic [21:0] GFX_BASE   = 22'h10000,
   parameter int          PROM_NUM   = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_downloading,
   input  logic                i_ioctl_wr,
   input  logic [24:0]         i_ioctl_addr,
   input  logic [7:0]          i_ioctl_data,
   output logic [21:0]         o_prog_addr,
   output logic [7:0]          o_prog_data,
   output logic [1:0]          o_prog_mask,
   output logic                o_prog_we,
   input  logic                i_prog_ack,
   output logic [PROM_NUM-1:0] o_prom_we,
   output logic [7:0]          o_prom_addr,
   output logic [3:0]          o_prom_data,
   output logic                o_dl_done,
   output logic                o_dl_ovf
);

   localparam logic [24:0] c_PROM_END = PROM_START + 25'(256 * PROM_NUM);

   dl_state_e     r_state;
   logic          r_done;
   logic          r_ovf;
   logic          r_dec_valid;
   dl_entry_t     r_dec;
   logic [PROM_NUM-1:0] r_prom_we;
   logic [7:0]    r_prom_addr;
   logic [3:0]    r_prom_data;

   dl_region_e    w_region;
   logic [21:0]   w_word;
   logic [PROM_NUM-1:0] w_prom_hot;
   logic          w_take;
   logic          w_is_sdram;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic          w_full;
   logic          w_empty;
   logic          w_drained;
   logic          w_enter_load;
   dl_entry_t     w_head;

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_region = RG_NONE;
      w_word   = '0;
      if (i_ioctl_addr < SND_START) begin
         w_region = RG_MAIN;
         w_word   = 22'(i_ioctl_addr >> 1);
      end else if (i_ioctl_addr < CHAR_START) begin
         w_region = RG_SND;
         w_word   = 22'({3'b000, SND_BASE} + ((i_ioctl_addr - SND_START) >> 1));
      end else if (i_ioctl_addr < GFX_START) begin
         w_region = RG_CHAR;
         w_word   = 22'({3'b000, CHAR_BASE} + ((i_ioctl_addr - CHAR_START) >> 1));
      end else if (i_ioctl_addr < PROM_START) begin
         w_region = RG_GFX;
         w_word   = 22'({3'b000, GFX_BASE} + ((i_ioctl_addr - GFX_START) >> 1));
      end else if (i_ioctl_addr < c_PROM_END) begin
         w_region = RG_PROM;
      end
   end

   // Each PROM owns a consecutive 256-byte window above PROM_START
   always_comb begin
      w_prom_hot = '0;
      for (int i = 0; i < PROM_NUM; i++) begin
         if ((i_ioctl_addr >= PROM_START + 25'(i * 256)) &&
             (i_ioctl_addr <  PROM_START + 25'(i * 256 + 256)))
            w_prom_hot[i] = 1'b1;
      end
   end

   assign w_take     = (r_state == LOAD) && i_ioctl_wr;
   assign w_is_sdram = (w_region != RG_PROM) && (w_region != RG_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dec_valid <= 1'b0;
         r_dec       <= '0;
         r_prom_we   <= '0;
         r_prom_addr <= '0;
         r_prom_data <= '0;
      end else begin
         r_dec_valid <= w_take && w_is_sdram;
         r_prom_we   <= '0;
         if (w_take && w_is_sdram) begin
            r_dec.addr <= w_word;
            r_dec.data <= i_ioctl_data;
            r_dec.mask <= i_ioctl_addr[0] ? 2'b01 : 2'b10;
         end
         if (w_take && (w_region == RG_PROM)) begin
            r_prom_we   <= w_prom_hot;
            r_prom_addr <= i_ioctl_addr[7:0];
            r_prom_data <= i_ioctl_data[3:0];
         end
      end
   end

   // ------------------------------------------------------------------ FIFO
   assign w_pop  = i_prog_ack && !w_empty;
   assign w_drop = r_dec_valid && w_full && !w_pop;
   assign w_push = r_dec_valid && !w_drop;

   jt1943_dl_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_entry (r_dec),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // ------------------------------------------------------------------- FSM
   // Leaving FLUSH is decided on the edge that empties the FIFO, so dl_done
   // is visible in the first cycle with prog_we low. A full FIFO (2 entries)
   // is never drained by a single pop; one entry with a pop and nothing in
   // the decode stage is.
   assign w_drained    = !r_dec_valid && (w_empty || (w_pop && !w_full));
   assign w_enter_load = (r_state != LOAD) && i_downloading;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE:    if (i_downloading) r_state <= LOAD;
            LOAD:    if (!i_downloading) r_state <= FLUSH;
            FLUSH: begin
               if (i_downloading) begin
                  r_state <= LOAD;
               end else if (w_drained) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_enter_load)
            r_ovf <= 1'b0;
         else if (w_drop)
            r_ovf <= 1'b1;
      end
   end

   // --------------------------------------------------------------- outputs
   assign o_prog_we   = !w_empty;
   assign o_prog_addr = w_head.addr;
   assign o_prog_data = w_head.data;
   assign o_prog_mask = w_head.mask;
   assign o_prom_we   = r_prom_we;
   assign o_prom_addr = r_prom_addr;
   assign o_prom_data = r_prom_data;
   assign o_dl_done   = r_done;
   assign o_dl_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_jt1943_dl_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt1943_dl_mapper
//  Purpose  : Directed self-checking bench for jt1943_dl_mapper.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jt1943_dl_mapper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_downloading = 1'b0;
   logic        i_ioctl_wr = 1'b0;
   logic [24:0] i_ioctl_addr = '0;
   logic [7:0]  i_ioctl_data = '0;
   logic [21:0] o_prog_addr;
   logic [7:0]  o_prog_data;
   logic [1:0]  o_prog_mask;
   logic        o_prog_we;
   logic        i_prog_ack = 1'b0;
   logic [11:0] o_prom_we;
   logic [7:0]  o_prom_addr;
   logic [3:0]  o_prom_data;
   logic        o_dl_done;
   logic        o_dl_ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   jt1943_dl_mapper dut (
      .clk           (clk),
      .rst           (rst),
      .i_downloading (i_downloading),
      .i_ioctl_wr    (i_ioctl_wr),
      .i_ioctl_addr  (i_ioctl_addr),
      .i_ioctl_data  (i_ioctl_data),
      .o_prog_addr   (o_prog_addr),
      .o_prog_data   (o_prog_data),
      .o_prog_mask   (o_prog_mask),
      .o_prog_we     (o_prog_we),
      .i_prog_ack    (i_prog_ack),
      .o_prom_we     (o_prom_we),
      .o_prom_addr   (o_prom_addr),
      .o_prom_data   (o_prom_data),
      .o_dl_done     (o_dl_done),
      .o_dl_ovf      (o_dl_ovf)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte for one cycle, then leave the bus idle (1 edge)
   task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
      i_ioctl_wr   = 1'b1;
      i_ioctl_addr = a;
      i_ioctl_data = d;
      tick();
      i_ioctl_wr   = 1'b0;
   endtask

   task automatic ack_once();
      i_prog_ack = 1'b1;
      tick();
      i_prog_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({o_prog_we, o_prog_addr, o_prog_data, o_prog_mask} !== 33'd0) begin
         n_errors++;
         $display("FAIL reset_prog: got we=%0b addr=%h data=%h mask=%b, want all 0",
                  o_prog_we, o_prog_addr, o_prog_data, o_prog_mask);
      end
      n_checks++;
      if ({o_prom_we, o_prom_addr, o_prom_data, o_dl_done, o_dl_ovf} !== 26'd0) begin
         n_errors++;
         $display("FAIL reset_misc: got prom_we=%h prom_addr=%h prom_data=%h done=%b ovf=%b, want all 0",
                  o_prom_we, o_prom_addr, o_prom_data, o_dl_done, o_dl_ovf);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_ignored();
      put_byte(25'h00002, 8'h77);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b0 || o_prom_we !== 12'h000) begin
         n_errors++;
         $display("FAIL idle_wr_ignored: got prog_we=%b prom_we=%h, want 0 0", o_prog_we, o_prom_we);
      end
   endtask

   task automatic test_main_byte();
      i_downloading = 1'b1;
      tick();
      put_byte(25'h00001, 8'h3C);
      n_checks++;
      if (o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL main_n1_we: got %b, want 0", o_prog_we);
      end
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h0 || o_prog_mask !== 2'b01 || o_prog_data !== 8'h3C) begin
         n_errors++;
         $display("FAIL main_n2: got we=%b addr=%h mask=%b data=%h, want 1 000000 01 3c",
                  o_prog_we, o_prog_addr, o_prog_mask, o_prog_data);
      end
      tick(); tick(); tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h0 || o_prog_data !== 8'h3C) begin
         n_errors++;
         $display("FAIL main_hold: got we=%b addr=%h data=%h, want 1 000000 3c",
                  o_prog_we, o_prog_addr, o_prog_data);
      end
      ack_once();
      n_checks++;
      if (o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL main_ack_drop: got we=%b, want 0", o_prog_we);
      end
   endtask

   task automatic test_regions();
      put_byte(25'h14006, 8'h11);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h0C003 || o_prog_mask !== 2'b10 || o_prog_data !== 8'h11) begin
         n_errors++;
         $display("FAIL char_region: got we=%b addr=%h mask=%b data=%h, want 1 00c003 10 11",
                  o_prog_we, o_prog_addr, o_prog_mask, o_prog_data);
      end
      ack_once();
      put_byte(25'h1C000, 8'h22);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h10000 || o_prog_mask !== 2'b10) begin
         n_errors++;
         $display("FAIL gfx_region: got we=%b addr=%h mask=%b, want 1 010000 10",
                  o_prog_we, o_prog_addr, o_prog_mask);
      end
      ack_once();
      put_byte(25'h0C005, 8'h33);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h08002 || o_prog_mask !== 2'b01) begin
         n_errors++;
         $display("FAIL snd_region: got we=%b addr=%h mask=%b, want 1 008002 01",
                  o_prog_we, o_prog_addr, o_prog_mask);
      end
      ack_once();
      put_byte(25'h0BFFF, 8'h44);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h05FFF || o_prog_mask !== 2'b01) begin
         n_errors++;
         $display("FAIL main_top: got we=%b addr=%h mask=%b, want 1 005fff 01",
                  o_prog_we, o_prog_addr, o_prog_mask);
      end
      ack_once();
   endtask

   task automatic test_prom();
      put_byte(25'h9C203, 8'h5A);
      n_checks++;
      if (o_prom_we !== 12'h004 || o_prom_addr !== 8'h03 || o_prom_data !== 4'hA || o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL prom_write: got prom_we=%h addr=%h data=%h prog_we=%b, want 004 03 a 0",
                  o_prom_we, o_prom_addr, o_prom_data, o_prog_we);
      end
      tick();
      n_checks++;
      if (o_prom_we !== 12'h000 || o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL prom_pulse_end: got prom_we=%h prog_we=%b, want 000 0", o_prom_we, o_prog_we);
      end
      put_byte(25'h9CBFF, 8'hF6);
      n_checks++;
      if (o_prom_we !== 12'h800 || o_prom_addr !== 8'hFF || o_prom_data !== 4'h6) begin
         n_errors++;
         $display("FAIL prom_last: got prom_we=%h addr=%h data=%h, want 800 ff 6",
                  o_prom_we, o_prom_addr, o_prom_data);
      end
      put_byte(25'h9CC00, 8'h99);
      n_checks++;
      if (o_prom_we !== 12'h000) begin
         n_errors++;
         $display("FAIL prom_beyond: got prom_we=%h, want 000", o_prom_we);
      end
      tick();
      n_checks++;
      if (o_prog_we !== 1'b0 || o_dl_ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL beyond_discard: got prog_we=%b ovf=%b, want 0 0", o_prog_we, o_dl_ovf);
      end
   endtask

   task automatic test_overflow();
      i_ioctl_wr = 1'b1;
      i_ioctl_addr = 25'h00010; i_ioctl_data = 8'hA1; tick();
      i_ioctl_addr = 25'h00011; i_ioctl_data = 8'hA2; tick();
      i_ioctl_addr = 25'h00012; i_ioctl_data = 8'hA3; tick();
      i_ioctl_wr = 1'b0; tick();
      n_checks++;
      if (o_dl_ovf !== 1'b1 || o_prog_we !== 1'b1 || o_prog_addr !== 22'h8 ||
          o_prog_data !== 8'hA1 || o_prog_mask !== 2'b10) begin
         n_errors++;
         $display("FAIL ovf_set: got ovf=%b we=%b addr=%h data=%h mask=%b, want 1 1 000008 a1 10",
                  o_dl_ovf, o_prog_we, o_prog_addr, o_prog_data, o_prog_mask);
      end
      i_downloading = 1'b0;
      tick(); tick();
      n_checks++;
      if (o_dl_ovf !== 1'b1 || o_dl_done !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_sticky: got ovf=%b done=%b, want 1 0", o_dl_ovf, o_dl_done);
      end
      i_downloading = 1'b1;
      tick();
      n_checks++;
      if (o_dl_ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_clear_on_load: got ovf=%b, want 0", o_dl_ovf);
      end
      ack_once();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h8 || o_prog_data !== 8'hA2 || o_prog_mask !== 2'b01) begin
         n_errors++;
         $display("FAIL ovf_second: got we=%b addr=%h data=%h mask=%b, want 1 000008 a2 01",
                  o_prog_we, o_prog_addr, o_prog_data, o_prog_mask);
      end
      ack_once();
      n_checks++;
      if (o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_third_dropped: got we=%b, want 0", o_prog_we);
      end
   endtask

   task automatic test_back_to_back();
      i_ioctl_wr = 1'b1;
      i_ioctl_addr = 25'h00020; i_ioctl_data = 8'hB1; tick();
      i_ioctl_addr = 25'h00021; i_ioctl_data = 8'hB2; tick();
      i_ioctl_addr = 25'h00022; i_ioctl_data = 8'hB3; tick();
      i_ioctl_wr = 1'b0;
      i_prog_ack = 1'b1;
      tick();
      i_prog_ack = 1'b0;
      n_checks++;
      if (o_dl_ovf !== 1'b0 || o_prog_we !== 1'b1 || o_prog_addr !== 22'h10 ||
          o_prog_data !== 8'hB2 || o_prog_mask !== 2'b01) begin
         n_errors++;
         $display("FAIL full_pushpop: got ovf=%b we=%b addr=%h data=%h mask=%b, want 0 1 000010 b2 01",
                  o_dl_ovf, o_prog_we, o_prog_addr, o_prog_data, o_prog_mask);
      end
      ack_once();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h11 || o_prog_data !== 8'hB3 || o_prog_mask !== 2'b10) begin
         n_errors++;
         $display("FAIL full_third_kept: got we=%b addr=%h data=%h mask=%b, want 1 000011 b3 10",
                  o_prog_we, o_prog_addr, o_prog_data, o_prog_mask);
      end
      ack_once();
      n_checks++;
      if (o_prog_we !== 1'b0 || o_dl_ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL full_drain: got we=%b ovf=%b, want 0 0", o_prog_we, o_dl_ovf);
      end
   endtask

   task automatic test_flush_done();
      int done_cnt;
      int done_at;
      done_cnt = 0;
      done_at  = -1;
      put_byte(25'h00030, 8'hC1);
      put_byte(25'h00031, 8'hC2);
      tick();
      i_downloading = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         i_prog_ack = (c % 3 == 0);
         tick();
         if (o_dl_done === 1'b1) begin
            done_cnt++;
            done_at = c;
         end
      end
      i_prog_ack = 1'b0;
      n_checks++;
      if (done_cnt != 1) begin
         n_errors++;
         $display("FAIL done_count: got %0d pulses, want 1", done_cnt);
      end
      n_checks++;
      if (done_at != 6) begin
         n_errors++;
         $display("FAIL done_timing: got pulse after cycle %0d, want after cycle 6", done_at);
      end
      n_checks++;
      if (o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_empty: got we=%b, want 0", o_prog_we);
      end
   endtask

   task automatic test_rst_mid();
      i_downloading = 1'b1;
      tick();
      put_byte(25'h00040, 8'hD1);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_pre_pending: got we=%b, want 1", o_prog_we);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_drop: got we=%b, want 0", o_prog_we);
      end
      tick();
      put_byte(25'h14001, 8'hE5);
      tick();
      n_checks++;
      if (o_prog_we !== 1'b1 || o_prog_addr !== 22'h0C000 || o_prog_data !== 8'hE5 || o_prog_mask !== 2'b01) begin
         n_errors++;
         $display("FAIL rst_resume: got we=%b addr=%h data=%h mask=%b, want 1 00c000 e5 01",
                  o_prog_we, o_prog_addr, o_prog_data, o_prog_mask);
      end
      ack_once();
      n_checks++;
      if (o_prog_we !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_no_replay: got we=%b, want 0", o_prog_we);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignored();
      test_main_byte();
      test_regions();
      test_prom();
      test_overflow();
      test_back_to_back();
      test_flush_done();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
